legv8_mc_control: RTL
=====================

# legv8_mc_control

Multi-cycle main control unit for the LEGv8 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. Each state drives the datapath mux selects and write enables, plus the 2-bit ALUOp code consumed by the downstream ALU control block. It sits between the instruction register (opcode source) and the datapath/ALU control, and handshakes with the unified instruction/data memory.

## Interface

- Parameters: none; state and opcode encodings come from the shared package.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  11  IR[31:21]; valid from DECODE onward
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
- ALUOp  out  2  00 add, 01 pass/test B (CBZ), 10 R-type funct decode
- ALUSrcA  out  1  0 PC, 1 register A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 branch offset<<2
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, Reg2Loc, PCWrite, PCWriteCond  out  1 each
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- retired  out  1  one-cycle pulse in the final cycle of each legal instruction
- illegal  out  1  sticky; set on an undecodable opcode
- state  out  4  current state, for debug

## Operation

- Moore FSM. Outputs decode from the state register only, except that IRWrite and PCWrite in FETCH and retired in the memory states are gated by mem_ready. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready. Hold until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Reg2Loc=1 for STUR/CBZ. Next state by opcode priority:
  - B (opcode[10:5]=000101) -> JUMP
  - CBZ ([10:3]=10110100) -> BRANCH
  - LDUR (11111000010) or STUR (11111000000) -> MEM_ADDR
  - ADD/SUB/AND/ORR (10001011000/11001011000/10001010000/10101010000) -> R_EXEC
  - anything else -> set illegal, go to FETCH, no retired pulse
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ for LDUR, MEM_WRITE for STUR.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, retired=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, retired=mem_ready. Hold until mem_ready, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegWrite=1, MemtoReg=0, retired=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retired=1. Go to FETCH. The datapath ANDs PCWriteCond with zero.
- JUMP: PCWrite=1, PCSource=10, retired=1. Go to FETCH.
- Opcode is compared at full 11-bit width. The x bits of B and CBZ are don't-care and are implemented by bit-slice compare.

## Timing

- Reset: state=FETCH, illegal=0. While rst=1, every write enable (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) and retired are forced to 0. Mux selects show their FETCH values.
- Reset mid-instruction aborts the instruction. Nothing is written in the reset cycle. FETCH begins in the first cycle after rst deasserts.
- Latencies with mem_ready held at 1: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3, illegal 2 (FETCH, DECODE).
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. The state holds and all outputs stay stable.
- illegal updates on the clock edge leaving DECODE and holds until rst.
- retired never asserts in two consecutive cycles.

## Structure

- Package legv8_ctrl_pkg holds:
  - state enum (4-bit, FETCH=0 … JUMP=9)
  - ALUOp constants
  - ALUSrcB and PCSource select constants
  - opcode match constants and masks
- The ALU control block imports the same ALUOp constants from this package.
- One sub-module, legv8_opcode_decode: combinational, maps opcode to a one-hot instruction class {R, LD, ST, CBZ, B, ILL}. The FSM uses the class in DECODE and MEM_ADDR.

## Test plan

- R-type ADD (opcode 10001011000), mem_ready=1: states 0,1,6,7,0. ALUOp=10 in R_EXEC. RegWrite=1 and retired=1 only in R_WB.
- LDUR with mem_ready low for 2 cycles in MEM_READ: states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 throughout MEM_READ. MemtoReg=1 in MEM_WB.
- CBZ (10110100101): DECODE shows Reg2Loc=1. BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01, retired=1.
- B (00010111111): 3-cycle sequence. JUMP shows PCWrite=1, PCSource=10.
- Opcode 00000000000: illegal rises after DECODE, state returns to FETCH, no retired pulse. illegal stays 1 through a following ADD and clears only on rst.
- rst asserted in R_EXEC: next state FETCH, RegWrite never asserted, illegal=0.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control path.
// Holds the FSM state encoding, the ALUOp codes (also used by the ALU
// control block), datapath mux select codes, opcode match/mask pairs and
// the one-hot instruction class produced by legv8_opcode_decode.
package legv8_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    // ALUOp codes consumed by the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // PCSource selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Opcode match values and masks; B and CBZ carry don't-care low bits
    localparam logic [10:0] OP_B_MATCH   = 11'b000101_00000;
    localparam logic [10:0] OP_B_MASK    = 11'b111111_00000;
    localparam logic [10:0] OP_CBZ_MATCH = 11'b10110100_000;
    localparam logic [10:0] OP_CBZ_MASK  = 11'b11111111_000;
    localparam logic [10:0] OP_FULL_MASK = 11'b11111111111;
    localparam logic [10:0] OP_LDUR      = 11'b11111000010;
    localparam logic [10:0] OP_STUR      = 11'b11111000000;
    localparam logic [10:0] OP_ADD       = 11'b10001011000;
    localparam logic [10:0] OP_SUB       = 11'b11001011000;
    localparam logic [10:0] OP_AND       = 11'b10001010000;
    localparam logic [10:0] OP_ORR       = 11'b10101010000;

    // One-hot instruction class
    typedef struct packed {
        logic r;
        logic ld;
        logic st;
        logic cbz;
        logic b;
        logic ill;
    } iclass_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] match,
                                      input logic [10:0] mask);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode classifier.
//   opcode : in  11  IR[31:21]
//   iclass : out 6   one-hot {r, ld, st, cbz, b, ill}
// Priority: B, CBZ, LDUR/STUR, R-type; anything else is illegal.
module legv8_opcode_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     iclass
);

    always_comb begin
        iclass = '0;
        if (op_match(opcode, OP_B_MATCH, OP_B_MASK))
            iclass.b = 1'b1;
        else if (op_match(opcode, OP_CBZ_MATCH, OP_CBZ_MASK))
            iclass.cbz = 1'b1;
        else if (op_match(opcode, OP_LDUR, OP_FULL_MASK))
            iclass.ld = 1'b1;
        else if (op_match(opcode, OP_STUR, OP_FULL_MASK))
            iclass.st = 1'b1;
        else if (op_match(opcode, OP_ADD, OP_FULL_MASK) ||
                 op_match(opcode, OP_SUB, OP_FULL_MASK) ||
                 op_match(opcode, OP_AND, OP_FULL_MASK) ||
                 op_match(opcode, OP_ORR, OP_FULL_MASK))
            iclass.r = 1'b1;
        else
            iclass.ill = 1'b1;
    end

endmodule

// File: rtl/legv8_mc_control.sv
// LEGv8 multi-cycle main control FSM.
//   clk, rst       : clock, synchronous active-high reset
//   opcode         : IR[31:21], valid from DECODE onward
//   zero           : ALU zero flag (branch resolved in datapath via PCWriteCond)
//   mem_ready      : unified memory handshake
//   ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, RegWrite,
//   MemtoReg, Reg2Loc, PCWrite, PCWriteCond, PCSource : datapath controls
//   retired        : pulse in final cycle of each legal instruction
//   illegal        : sticky undecodable-opcode flag
//   state          : current state, debug
module legv8_mc_control
    import legv8_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALUOp,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        Reg2Loc,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        retired,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t  state_q;
    state_t  state_d;
    state_t  dec_state;
    iclass_t iclass;

    // The branch decision is the datapath's AND of PCWriteCond and zero,
    // so the FSM itself never looks at the flag.
    logic unused_zero;
    assign unused_zero = zero;

    legv8_opcode_decode u_decode (
        .opcode (opcode),
        .iclass (iclass)
    );

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (iclass.b)                    state_d = S_JUMP;
                else if (iclass.cbz)             state_d = S_BRANCH;
                else if (iclass.ld || iclass.st) state_d = S_MEM_ADDR;
                else if (iclass.r)               state_d = S_R_EXEC;
                else                             state_d = S_FETCH;
            end
            S_MEM_ADDR:  state_d = iclass.st ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && iclass.ill)
                illegal <= 1'b1;
        end
    end

    // During reset the selects decode as FETCH; enables are masked below.
    assign dec_state = rst ? S_FETCH : state_q;

    always_comb begin
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 1'b0;
        Reg2Loc     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        retired     = 1'b0;
        unique case (dec_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BROFF;
                Reg2Loc = iclass.st | iclass.cbz;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retired  = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retired  = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                retired  = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_PASSB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                retired     = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                retired  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            retired     = 1'b0;
        end
    end

endmodule
